// File: rtl/led_sequencer.sv
// Register-programmable LED pattern sequencer (static, blink, rotate, bounce) with a 4-word slave port.
// Optional wrap interrupt output is built only when LED_SEQ_IRQ_EN is defined.
module led_sequencer #(
  parameter int WIDTH      = 10,
  parameter int PRESCALE_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    M_STATIC = 2'd0,
    M_BLINK  = 2'd1,
    M_ROTATE = 2'd2,
    M_BOUNCE = 2'd3
  } mode_t;

  state_t                state_q, state_d;
  mode_t                 mode_q;
  logic [WIDTH-1:0]      pattern_q, pattern_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [PRESCALE_W-1:0] period_q, period_m1, prescale_q;
  logic [IDX_W-1:0]      step_idx_q;
  logic                  phase_q;
  logic                  dir_right_q, dir_right_d;
  logic                  wrap_q, irq_mask_q;
  logic                  running, load, tick, wrap_evt;
  logic                  wr_en, wr_ctrl, wr_pattern, wr_period, wr_status;

  assign wr_en      = chipselect & ~write_n;
  assign wr_ctrl    = wr_en && (address == 2'd0);
  assign wr_pattern = wr_en && (address == 2'd1);
  assign wr_period  = wr_en && (address == 2'd2);
  assign wr_status  = wr_en && (address == 2'd3);
  assign running    = (state_q == S_RUN);

  // A PATTERN write that coincides with a load must reload the new value, not the stale one.
  assign pattern_d  = wr_pattern ? writedata[WIDTH-1:0] : pattern_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    load    = 1'b0;
    if (wr_ctrl) begin
      state_d = writedata[0] ? S_RUN : S_IDLE;
    end
    if (state_q == S_RUN) begin
      load = wr_ctrl | wr_pattern | wr_period;
    end else begin
      load = (state_d == S_RUN);
    end
  end

  // ---------------------------------------------------------------- programmable registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= M_STATIC;
      pattern_q <= '0;
      period_q  <= '0;
    end else begin
      if (wr_ctrl) begin
        mode_q <= mode_t'(writedata[2:1]);
      end
      pattern_q <= pattern_d;
      if (wr_period) begin
        period_q <= writedata[PRESCALE_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- step timing
  // PERIOD of 0 is treated as 1, so both give a terminal count of 0.
  assign period_m1 = (period_q == '0) ? '0 : period_q - PRESCALE_W'(1);
  assign tick      = running && (prescale_q == period_m1);
  assign wrap_evt  = tick && !load && (step_idx_q == LAST_IDX);

  always_comb begin
    shift_d     = shift_q;
    dir_right_d = dir_right_q;
    case (mode_q)
      M_ROTATE: shift_d = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
      M_BOUNCE: begin
        if (!dir_right_q) begin
          if (shift_q[WIDTH-1]) begin
            dir_right_d = 1'b1;
            shift_d     = shift_q >> 1;
          end else begin
            shift_d = shift_q << 1;
          end
        end else begin
          if (shift_q[0]) begin
            dir_right_d = 1'b0;
            shift_d     = shift_q << 1;
          end else begin
            shift_d = shift_q >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  // Load beats a coincident step tick: the branch order below discards that step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      prescale_q  <= '0;
      step_idx_q  <= '0;
      phase_q     <= 1'b1;
      dir_right_q <= 1'b0;
    end else if (load) begin
      shift_q     <= pattern_d;
      prescale_q  <= '0;
      step_idx_q  <= '0;
      phase_q     <= 1'b1;
      dir_right_q <= 1'b0;
    end else if (!running) begin
      prescale_q <= '0;
      step_idx_q <= '0;
    end else if (tick) begin
      prescale_q  <= '0;
      step_idx_q  <= (step_idx_q == LAST_IDX) ? '0 : step_idx_q + IDX_W'(1);
      phase_q     <= ~phase_q;
      shift_q     <= shift_d;
      dir_right_q <= dir_right_d;
    end else begin
      prescale_q <= prescale_q + PRESCALE_W'(1);
    end
  end

  // ---------------------------------------------------------------- wrap flag / interrupt
`ifdef LED_SEQ_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q     <= 1'b0;
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wrap_evt) begin
        wrap_q <= 1'b1;
      end else if (wr_status && writedata[1]) begin
        wrap_q <= 1'b0;
      end
      if (wr_ctrl) begin
        irq_mask_q <= writedata[3];
      end
      irq_q <= wrap_q & irq_mask_q;
    end
  end

  assign irq = irq_q;
`else
  assign wrap_q     = 1'b0;
  assign irq_mask_q = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{writedata, wrap_evt, wr_status};

  // ---------------------------------------------------------------- outputs
  always_comb begin
    out_port = pattern_q;
    if (running) begin
      case (mode_q)
        M_BLINK:            out_port = phase_q ? pattern_q : '0;
        M_ROTATE, M_BOUNCE: out_port = shift_q;
        default:            ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[3:0] = {irq_mask_q, mode_q, running};
      2'd1: readdata[WIDTH-1:0] = pattern_q;
      2'd2: readdata[PRESCALE_W-1:0] = period_q;
      2'd3: begin
        readdata[15:8] = 8'(step_idx_q);
        readdata[1]    = wrap_q;
        readdata[0]    = running;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed scenarios plus random register traffic,
// compared every cycle against a step-count based reference model.
module tb_led_sequencer;

  localparam int          W    = 10;
  localparam logic [31:0] MASK = 32'h3FF;
`ifdef LED_SEQ_IRQ_EN
  localparam bit IRQ = 1'b1;
  logic irq;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] out_port;

  int checks   = 0;
  int failures = 0;

  led_sequencer #(.WIDTH(W), .PRESCALE_W(24)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: sequencer state expressed as clocks and whole steps since the last load.
  logic        m_run, m_mask, m_wrap, m_irq;
  logic [1:0]  m_mode;
  logic [31:0] m_pat, m_per;
  int          m_c, m_steps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_mask = 0; m_wrap = 0; m_irq = 0; m_mode = 0;
    m_pat = 0; m_per = 0; m_c = 0; m_steps = 0;
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] p, input int n);
    int k;
    k = n % W;
    return ((p << k) | (p >> (W - k))) & MASK;
  endfunction

  function automatic logic [31:0] bounce_after(input logic [31:0] p, input int n);
    logic [31:0] r;
    bit right;
    r = p;
    right = 0;
    for (int i = 0; i < n; i++) begin
      if (!right) begin
        if (r[W-1]) begin right = 1; r = r >> 1; end
        else r = (r << 1) & MASK;
      end else begin
        if (r[0]) begin right = 0; r = (r << 1) & MASK; end
        else r = r >> 1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_out();
    if (!m_run) return m_pat;
    case (m_mode)
      2'd1:    return (m_steps % 2 == 0) ? m_pat : 32'h0;
      2'd2:    return rotl(m_pat, m_steps);
      2'd3:    return bounce_after(m_pat, m_steps);
      default: return m_pat;
    endcase
  endfunction

  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[3:0] = {m_mask, m_mode, m_run};
      2'd1: r = m_pat;
      2'd2: r = m_per;
      default: begin
        r[15:8] = 8'(m_steps % W);
        r[1]    = m_wrap;
        r[0]    = m_run;
      end
    endcase
    return r;
  endfunction

  task automatic model_edge(input logic wr, input logic [1:0] a, input logic [31:0] d);
    int   pd;
    logic was_run, load, step, wrap_set;
    pd       = (m_per == 0) ? 1 : int'(m_per);
    was_run  = m_run;
    load     = wr && ((a == 2'd0 && d[0] && !was_run) || (was_run && a != 2'd3));
    step     = was_run && !load && ((m_c + 1) % pd == 0);
    wrap_set = IRQ && step && ((m_steps + 1) % W == 0);
    m_irq    = IRQ && m_wrap && m_mask;
    if (wr) begin
      case (a)
        2'd0: begin m_run = d[0]; m_mode = d[2:1]; m_mask = IRQ && d[3]; end
        2'd1: m_pat = d & MASK;
        2'd2: m_per = d & 32'h00FF_FFFF;
        default: if (IRQ && d[1]) m_wrap = 0;
      endcase
    end
    if (load) begin
      m_c = 0; m_steps = 0;
    end else if (was_run) begin
      m_c++;
      if (step) m_steps++;
    end
    if (!m_run) begin m_c = 0; m_steps = 0; end
    if (wrap_set) m_wrap = 1;
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next fall.
  task automatic cycle(input logic wr, input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = wr; write_n = !wr; writedata = d;
    @(posedge clk);
    model_edge(wr, a, d);
    @(negedge clk);
    chipselect = 0; write_n = 1;
    check("out_port", 32'(out_port), exp_out());
`ifdef LED_SEQ_IRQ_EN
    check("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'h0);
  endtask

  task automatic read_check(input logic [1:0] a);
    address = a; chipselect = 1; write_n = 1;
    #1 check($sformatf("read_addr%0d", a), readdata, exp_reg(a));
    chipselect = 0;
  endtask

  initial begin
    logic [31:0] d;
    int          op;
    reset_n = 0; address = 0; chipselect = 0; write_n = 1; writedata = 0;
    model_reset();
    #1 check("out_in_reset", 32'(out_port), 32'h0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) read_check(2'(a));
    check("reset_out", 32'(out_port), 32'h0);

    // Rotate a single bit every 4 clocks through a full wrap.
    write(2'd1, 32'h001);
    write(2'd2, 32'd4);
    write(2'd0, 32'h5);
    check("rot_first", 32'(out_port), 32'h001);
    idle(4);
    check("rot_step1", 32'(out_port), 32'h002);
    idle(32);
    check("rot_msb", 32'(out_port), 32'h200);
    read_check(2'd3);
    idle(4);
    check("rot_wrap_out", 32'(out_port), 32'h001);
    address = 2'd3;
    #1 check("rot_wrap_status", readdata, IRQ ? 32'h3 : 32'h1);

    // Readback widths and ignored bits, in IDLE.
    write(2'd0, 32'hFFFF_FFF8);
    read_check(2'd0);
    write(2'd2, 32'hFFFF_FFFF);
    read_check(2'd2);
    write(2'd1, 32'hFFFF_FFFF);
    read_check(2'd1);
    write(2'd3, 32'h2);
    read_check(2'd3);

    // Blink with PERIOD 0: toggles every clock.
    write(2'd1, 32'h3FF);
    write(2'd2, 32'd0);
    write(2'd0, 32'h3);
    check("blink_on", 32'(out_port), 32'h3FF);
    idle(1);
    check("blink_off", 32'(out_port), 32'h000);
    idle(6);

    // Bounce off the MSB, then reload on a tick cycle.
    write(2'd0, 32'h0);
    write(2'd1, 32'h100);
    write(2'd2, 32'd1);
    write(2'd0, 32'h7);
    check("bounce_0", 32'(out_port), 32'h100);
    idle(1);
    check("bounce_1", 32'(out_port), 32'h200);
    idle(1);
    check("bounce_2", 32'(out_port), 32'h100);
    idle(1);
    check("bounce_3", 32'(out_port), 32'h080);
    write(2'd1, 32'h003);
    check("bounce_reload", 32'(out_port), 32'h003);
    idle(3);
    write(2'd2, 32'd3);
    idle(2);
    write(2'd1, 32'h005);
    idle(2);
    check("prescale_restart", 32'(out_port), 32'h005);
    idle(1);
    check("bounce_after_restart", 32'(out_port), 32'h00A);

    // Zero pattern in rotate stays dark.
    write(2'd1, 32'h0);
    write(2'd0, 32'h5);
    idle(5);
    check("zero_rotate", 32'(out_port), 32'h0);

    // Wrap set and STATUS clear in the same cycle: set wins.
    write(2'd1, 32'h001);
    write(2'd2, 32'd1);
    write(2'd0, 32'hD);
    idle(9);
    write(2'd3, 32'h2);
    read_check(2'd3);
    idle(2);
    write(2'd3, 32'h2);
    idle(2);
    read_check(2'd3);

    // Masked wrap interrupt with PERIOD 2, then clear.
    write(2'd0, 32'h0);
    write(2'd2, 32'd2);
    write(2'd0, 32'hD);
    idle(22);
    read_check(2'd3);
    write(2'd3, 32'h2);
    idle(2);
    read_check(2'd0);

    // Random register traffic.
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: begin
          d = $urandom;
          d[0] = ($urandom_range(0, 3) != 0);
          write(2'd0, d);
        end
        2: write(2'd1, $urandom);
        3: write(2'd2, 32'($urandom_range(0, 3)));
        4: write(2'd3, $urandom);
        5: read_check(2'($urandom_range(0, 3)));
        default: idle(int'($urandom_range(1, 6)));
      endcase
    end
    for (int a = 0; a < 4; a++) read_check(2'(a));

    // Asynchronous reset in the middle of a run.
    write(2'd1, 32'h0F0);
    write(2'd2, 32'd1);
    write(2'd0, 32'h5);
    idle(3);
    address = 2'd3;
    #2 reset_n = 0;
    model_reset();
    #1 check("async_reset_out", 32'(out_port), 32'h0);
    check("async_reset_status", readdata, 32'h0);
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) read_check(2'(a));
    idle(3);
    check("post_reset_out", 32'(out_port), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
